// File: rtl/gate_apply_2q_if.sv
// Gate-opcode handshake and state-vector bus between a gate source and gate_apply_2q.
// master drives opcodes; slave (the gate engine) owns the amplitudes and status.
interface gate_apply_2q_if #(
    parameter int WIDTH = 16
);
    logic                    gate_valid;
    logic [2:0]              gate_op;
    logic                    gate_ready;
    logic signed [WIDTH-1:0] amp00_real;
    logic signed [WIDTH-1:0] amp00_imag;
    logic signed [WIDTH-1:0] amp01_real;
    logic signed [WIDTH-1:0] amp01_imag;
    logic signed [WIDTH-1:0] amp10_real;
    logic signed [WIDTH-1:0] amp10_imag;
    logic signed [WIDTH-1:0] amp11_real;
    logic signed [WIDTH-1:0] amp11_imag;
    logic                    state_valid;
    logic                    done;
    logic [7:0]              gate_count;

    modport master (
        output gate_valid, gate_op,
        input  gate_ready,
        input  amp00_real, amp00_imag, amp01_real, amp01_imag,
        input  amp10_real, amp10_imag, amp11_real, amp11_imag,
        input  state_valid, done, gate_count
    );

    modport slave (
        input  gate_valid, gate_op,
        output gate_ready,
        output amp00_real, amp00_imag, amp01_real, amp01_imag,
        output amp10_real, amp10_imag, amp11_real, amp11_imag,
        output state_valid, done, gate_count
    );
endinterface

// File: rtl/gate_apply_2q.sv
// Two-qubit state-vector engine: applies one gate opcode at a time, two amplitude
// pairs per gate into shadow registers, then commits the whole vector at once.
module gate_apply_2q #(
    parameter int WIDTH     = 16,
    parameter int FRAC      = 7,
    parameter int INV_SQRT2 = 91
) (
    input logic            clk,
    input logic            reset,
    gate_apply_2q_if.slave bus
);
    localparam int PW = WIDTH + 9;
    localparam logic signed [WIDTH-1:0] ONE  = WIDTH'(1 << FRAC);
    localparam logic signed [PW-1:0]    PMAX = PW'((1 << (WIDTH - 1)) - 1);
    localparam logic signed [PW-1:0]    PMIN = ~PMAX;
    localparam logic signed [PW-1:0]    COEF = PW'(INV_SQRT2);

    typedef enum logic [1:0] {IDLE, PAIR0, PAIR1, COMMIT} state_t;

    state_t                  state, next_state;
    logic [2:0]              op_q;
    logic signed [WIDTH-1:0] re_q [4];
    logic signed [WIDTH-1:0] im_q [4];
    logic signed [WIDTH-1:0] re_sh[4];
    logic signed [WIDTH-1:0] im_sh[4];
    logic                    done_q;
    logic [7:0]              cnt_q;
    logic                    q1pair, second;
    logic [1:0]              ia, ib;
    logic signed [WIDTH-1:0] na_re, nb_re, na_im, nb_im;

    function automatic logic signed [PW-1:0] ext(input logic signed [WIDTH-1:0] a);
        return {{9{a[WIDTH-1]}}, a};
    endfunction

    function automatic logic signed [WIDTH-1:0] sat(input logic signed [PW-1:0] v);
        if (v > PMAX) return PMAX[WIDTH-1:0];
        if (v < PMIN) return PMIN[WIDTH-1:0];
        return v[WIDTH-1:0];
    endfunction

    function automatic logic signed [WIDTH-1:0] hmul(input logic signed [WIDTH-1:0] a,
                                                     input logic signed [WIDTH-1:0] b,
                                                     input logic sub);
        logic signed [PW-1:0] s;
        s = sub ? ext(a) - ext(b) : ext(a) + ext(b);
        return sat((s * COEF) >>> FRAC);
    endfunction

    function automatic logic signed [WIDTH-1:0] negs(input logic signed [WIDTH-1:0] a);
        return sat(-ext(a));
    endfunction

    // Returns {new_a, new_b} for the pair (a, b) selected by the current state.
    function automatic logic [2*WIDTH-1:0] xform(input logic [2:0] op, input logic sec,
                                                 input logic signed [WIDTH-1:0] a,
                                                 input logic signed [WIDTH-1:0] b);
        case (op)
            3'd1, 3'd2: return {b, a};
            3'd3, 3'd4: return {hmul(a, b, 1'b0), hmul(a, b, 1'b1)};
            3'd5:       return sec ? {b, a} : {a, b};
            3'd6:       return {a, negs(b)};
            3'd7:       return '0;
            default:    return {a, b};
        endcase
    endfunction

    // q1-type opcodes pair indices differing in bit 1; the rest pair on bit 0.
    always_comb begin
        q1pair = op_q inside {3'd2, 3'd4, 3'd5, 3'd6};
        second = (state == PAIR1);
        ia     = second ? (q1pair ? 2'd1 : 2'd2) : 2'd0;
        ib     = second ? 2'd3 : (q1pair ? 2'd2 : 2'd1);
        {na_re, nb_re} = xform(op_q, second, re_q[ia], re_q[ib]);
        {na_im, nb_im} = xform(op_q, second, im_q[ia], im_q[ib]);
        if (op_q == 3'd7 && !second) na_re = ONE;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (bus.gate_valid) next_state = PAIR0;
            PAIR0:   next_state = PAIR1;
            PAIR1:   next_state = COMMIT;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        bus.gate_ready  = (state == IDLE);
        bus.state_valid = (state == IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < 4; i++) begin
                re_q[i]  <= (i == 0) ? ONE : '0;
                im_q[i]  <= '0;
                re_sh[i] <= '0;
                im_sh[i] <= '0;
            end
            op_q   <= '0;
            done_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: if (bus.gate_valid) op_q <= bus.gate_op;
                PAIR0, PAIR1: begin
                    re_sh[ia] <= na_re;
                    re_sh[ib] <= nb_re;
                    im_sh[ia] <= na_im;
                    im_sh[ib] <= nb_im;
                end
                default: begin
                    re_q   <= re_sh;
                    im_q   <= im_sh;
                    done_q <= 1'b1;
                    if (cnt_q != 8'hFF) cnt_q <= cnt_q + 8'd1;
                end
            endcase
        end
    end

    assign bus.amp00_real = re_q[0];
    assign bus.amp00_imag = im_q[0];
    assign bus.amp01_real = re_q[1];
    assign bus.amp01_imag = im_q[1];
    assign bus.amp10_real = re_q[2];
    assign bus.amp10_imag = im_q[2];
    assign bus.amp11_real = re_q[3];
    assign bus.amp11_imag = im_q[3];
    assign bus.done       = done_q;
    assign bus.gate_count = cnt_q;
endmodule

// File: tb/tb_gate_apply_2q.sv
// Scoreboard bench for gate_apply_2q: stimulus pushes expected vectors, a monitor
// pops and compares them whenever done pulses.
module tb_gate_apply_2q;
    localparam int WIDTH = 16;

    typedef struct packed {
        logic [3:0][WIDTH-1:0] re;
        logic [3:0][WIDTH-1:0] im;
        logic [7:0]            cnt;
        logic [31:0]           cyc;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    exp_t q[$];
    int   mre[4];
    int   mim[4];
    int   mcnt;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    gate_apply_2q_if #(.WIDTH(WIDTH)) bus ();

    gate_apply_2q #(.WIDTH(WIDTH), .FRAC(7), .INV_SQRT2(91)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    task automatic chk(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_vec(input string name, input logic [3:0][WIDTH-1:0] ere,
                           input logic [3:0][WIDTH-1:0] eim);
        logic [3:0][WIDTH-1:0] are, aim;
        are = {bus.amp11_real, bus.amp10_real, bus.amp01_real, bus.amp00_real};
        aim = {bus.amp11_imag, bus.amp10_imag, bus.amp01_imag, bus.amp00_imag};
        tests++;
        if (are != ere || aim != eim) begin
            fails++;
            $display("FAIL %s: got re %0d %0d %0d %0d im %0d %0d %0d %0d, expected re %0d %0d %0d %0d im %0d %0d %0d %0d",
                     name, $signed(are[0]), $signed(are[1]), $signed(are[2]), $signed(are[3]),
                     $signed(aim[0]), $signed(aim[1]), $signed(aim[2]), $signed(aim[3]),
                     $signed(ere[0]), $signed(ere[1]), $signed(ere[2]), $signed(ere[3]),
                     $signed(eim[0]), $signed(eim[1]), $signed(eim[2]), $signed(eim[3]));
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (reset && bus.done) begin
            if (q.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                e = q.pop_front();
                chk_vec("vector", e.re, e.im);
                chk("gate_count", bus.gate_count, e.cnt);
                chk("done_latency", cyc, e.cyc);
                chk("done_idle", bus.state_valid, 1);
            end
        end
    end

    function automatic int sat16(input int v);
        if (v > 32767)  return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    // Reference gate on one component array, written per output index.
    function automatic int gate_elem(input int op, input int i, input int v[4], input bit is_re);
        int b;
        b = (op == 3) ? 1 : 2;
        case (op)
            1: return v[i ^ 1];
            2: return v[i ^ 2];
            3, 4: begin
                if ((i & b) == 0) return sat16(((v[i] + v[i | b]) * 91) >>> 7);
                else              return sat16(((v[i ^ b] - v[i]) * 91) >>> 7);
            end
            5: return ((i & 1) != 0) ? v[i ^ 2] : v[i];
            6: return ((i & 2) != 0) ? sat16(-v[i]) : v[i];
            7: return (is_re && i == 0) ? 128 : 0;
            default: return v[i];
        endcase
    endfunction

    function automatic exp_t model_exp();
        exp_t e;
        for (int k = 0; k < 4; k++) begin
            e.re[k] = WIDTH'(mre[k]);
            e.im[k] = WIDTH'(mim[k]);
        end
        e.cnt = 8'(mcnt);
        e.cyc = '0;
        return e;
    endfunction

    task automatic send(input logic [2:0] op, input exp_t e);
        int n = 0;
        while (!bus.gate_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("ready_wait", bus.gate_ready, 1);
        bus.gate_valid = 1'b1;
        bus.gate_op    = op;
        e.cyc          = 32'(cyc + 4);
        q.push_back(e);
        @(negedge clk);
        bus.gate_valid = 1'b0;
        bus.gate_op    = ~op;
    endtask

    // Directed gate: expected real amplitudes given by hand, imag all zero.
    task automatic push_gate(input logic [2:0] op, input int r0, input int r1,
                             input int r2, input int r3);
        mcnt = (mcnt < 255) ? mcnt + 1 : 255;
        mre  = '{r0, r1, r2, r3};
        mim  = '{0, 0, 0, 0};
        send(op, model_exp());
    endtask

    task automatic model_gate(input logic [2:0] op);
        int ore[4], oim[4];
        ore = mre;
        oim = mim;
        for (int i = 0; i < 4; i++) begin
            mre[i] = gate_elem(int'(op), i, ore, 1'b1);
            mim[i] = gate_elem(int'(op), i, oim, 1'b0);
        end
        mcnt = (mcnt < 255) ? mcnt + 1 : 255;
        send(op, model_exp());
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((q.size() != 0 || !bus.state_valid) && n < 100) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic check_ground(input string name);
        chk_vec(name, {16'd0, 16'd0, 16'd0, 16'd128}, '0);
        chk({name, "_count"}, bus.gate_count, 0);
        chk({name, "_ready"}, bus.gate_ready, 1);
        chk({name, "_sv"}, bus.state_valid, 1);
        chk({name, "_done"}, bus.done, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    initial begin
        reset          = 1'b0;
        bus.gate_valid = 1'b0;
        bus.gate_op    = 3'd0;
        mre  = '{128, 0, 0, 0};
        mim  = '{0, 0, 0, 0};
        mcnt = 0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_ground("reset");

        // H q0 from |00>, with busy-window status checks.
        push_gate(3'd3, 91, 91, 0, 0);
        chk("busy_sv_n1", bus.state_valid, 0);
        chk("busy_ready_n1", bus.gate_ready, 0);
        @(negedge clk);
        chk("busy_sv_n2", bus.state_valid, 0);
        // Bell state, then reload |00> after several gates.
        push_gate(3'd5, 91, 0, 0, 91);
        push_gate(3'd7, 128, 0, 0, 0);
        // H q0 twice: rounding growth 182*91>>>7 = 129.
        push_gate(3'd3, 91, 91, 0, 0);
        push_gate(3'd3, 129, 0, 0, 0);
        push_gate(3'd7, 128, 0, 0, 0);
        push_gate(3'd2, 0, 0, 128, 0);
        push_gate(3'd6, 0, 0, -128, 0);

        // Request held through busy with opcode changing afterwards: one identity gate only.
        wait_idle();
        bus.gate_valid = 1'b1;
        bus.gate_op    = 3'd0;
        mcnt = mcnt + 1;
        begin
            exp_t e;
            e = model_exp();
            e.cyc = 32'(cyc + 4);
            q.push_back(e);
        end
        @(negedge clk);
        bus.gate_op = 3'd7;
        @(negedge clk);
        bus.gate_op = 3'd3;
        @(negedge clk);
        bus.gate_valid = 1'b0;
        wait_idle();
        repeat (4) @(negedge clk);
        chk("held_count", bus.gate_count, mcnt);

        // Reset asserted while the gate sits in PAIR1: discarded, no done.
        bus.gate_valid = 1'b1;
        bus.gate_op    = 3'd1;
        @(negedge clk);
        bus.gate_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_ground("midreset");
        @(negedge clk);
        reset = 1'b1;
        mre  = '{128, 0, 0, 0};
        mim  = '{0, 0, 0, 0};
        mcnt = 0;
        repeat (6) @(negedge clk);
        check_ground("post_reset");

        // Drive amp10 to -32768: negative amplitudes grow under floor rounding.
        model_gate(3'd2);
        model_gate(3'd6);
        for (int k = 0; k < 3000 && mre[2] != -32768; k++) model_gate(3'd3);
        push_gate(3'd6, 0, 0, 32767, 0);
        push_gate(3'd1, 0, 0, 0, 32767);
        push_gate(3'd4, 0, 23295, 0, -23296);
        push_gate(3'd5, 0, -23296, 0, 23295);
        push_gate(3'd7, 128, 0, 0, 0);
        wait_idle();
        chk("final_count_sat", bus.gate_count, 255);
        chk("queue_drained", q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/gate_apply_2q.md
Name: gate_apply_2q

Overview:
- Upstream stage of the `measurement` block.
- Holds the 2-qubit state vector as four complex amplitudes (signed fixed point, ONE = 1.0).
- Applies single- or two-qubit gate opcodes one at a time through a valid/ready handshake.
- Its amplitude outputs connect directly to the measurement amplitude inputs. `state_valid` tells downstream the vector is stable.

Parameters:
- WIDTH, 16, amplitude width (signed, per real/imag component).
- FRAC, 7, fractional bits; ONE = 2^FRAC = 128 represents 1.0.
- INV_SQRT2, 91, fixed-point 1/sqrt(2) (91/128 ≈ 0.711).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- gate_valid  in  1  opcode offered.
- gate_op  in  3  opcode (see Behaviour).
- gate_ready  out  1  block can accept an opcode.
- amp00_real, amp00_imag, amp01_real, amp01_imag, amp10_real, amp10_imag, amp11_real, amp11_imag  out  WIDTH each  current state vector; index is b1b0, q0 = LSB.
- state_valid  out  1  high while the vector is stable (IDLE).
- done  out  1  one-cycle pulse when a gate commits.
- gate_count  out  8  number of committed gates, saturating at 255.

Behaviour:
- Reset (reset=0, asynchronous):
  - amp00_real = ONE (128); all other amplitude outputs = 0.
  - FSM = IDLE; gate_ready = 1; state_valid = 1; done = 0; gate_count = 0.
- Opcodes:
  - 0 I: no change.
  - 1 X q0: swap 00<->01 and 10<->11.
  - 2 X q1: swap 00<->10 and 01<->11.
  - 3 H q0: pairs (00,01) and (10,11).
  - 4 H q1: pairs (00,10) and (01,11).
  - 5 CNOT, control q0, target q1: swap 01<->11.
  - 6 Z q1: negate amplitudes 10 and 11.
  - 7 RST: reload |00> (amp00_real = ONE, all others 0).
- H on pair (a,b):
  - a' = sat((a+b)*INV_SQRT2 >>> FRAC); b' = sat((a-b)*INV_SQRT2 >>> FRAC).
  - Applied independently to real and imag components.
  - Sum/difference is WIDTH+1 bits; product is WIDTH+9 bits.
  - Shift is arithmetic (rounds toward -inf).
  - sat clamps to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
- Negate uses the same saturation: -(-32768) -> 32767.
- FSM states: IDLE -> PAIR0 -> PAIR1 -> COMMIT -> IDLE.
  - IDLE: gate_ready = 1, state_valid = 1. A handshake (gate_valid & gate_ready) at edge N latches gate_op and moves to PAIR0.
  - PAIR0: compute the first amplitude pair into shadow registers.
  - PAIR1: compute the second amplitude pair into shadow registers.
  - COMMIT: copy the shadow registers to the output registers in one cycle; increment gate_count.
- Latency: handshake at edge N; outputs and done change together at edge N+3. done is high for exactly cycle N+3 to N+4, and the FSM is back in IDLE in that cycle.
- Visible outputs never show a partially updated vector.
- Outside IDLE: gate_ready = 0, state_valid = 0, and gate_valid is ignored (no queueing).
- A new opcode may be accepted in the same cycle done is high (back-to-back throughput of one gate per 4 cycles).
- Opcodes 0 and 7 still take the full 4-cycle path, pulse done, and increment gate_count.
- gate_count holds at 255; it is cleared only by reset.
- Reset asserted mid-operation: immediate return to the reset values; the in-flight gate is discarded.
- Opcode values are registered at the handshake; gate_op changes afterwards have no effect.

Test Plan:
- Release reset -> amp00_real = 128, all other amplitudes 0, gate_ready = 1, state_valid = 1, gate_count = 0.
- Opcode 3 (H q0) accepted at edge N -> at N+3: amp00_real = 91, amp01_real = 91, others 0; done high for one cycle; gate_count = 1; state_valid low during N+1..N+2.
- H q0, then opcode 5 (CNOT) -> amp00_real = 91, amp11_real = 91, amp01 = amp10 = 0 (Bell state); gate_count = 2.
- H q0 twice -> amp00_real = 129 ((182*91)>>>7), amp01_real = 0.
- Opcode 2 (X q1) then opcode 6 (Z q1) -> amp10_real = 128 after the first gate, then -128; separately, preload amp10_real = -32768 via host gates and apply Z -> 32767.
- gate_valid held during busy -> ignored, gate_count unchanged by the held request.
- reset pulsed low at PAIR1 -> outputs immediately return to |00>; no done pulse.
- Opcode 7 after several gates -> vector returns to |00>, done pulses, gate_count increments.
